uart_dump: RTL

- Memory read-back transmitter: the outbound counterpart of the UART bootloader.
- On command, reads a range of words from instruction or data memory and serialises each word into the bootloader's 7-byte packet format. Packets go to a byte-level UART transmitter through its trmt/tx_done handshake.
- Lets the host verify loaded images and dump results after a run.
- Sits beside the bootloader receiver, muxed onto the memory read port while the CPU is held in reset.

---
 rtl/uart_dump.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_dump.sv
// rtl/uart_dump.sv - memory read-back transmitter for the UART bootloader link
//
// Reads word_count words from instruction or data memory, starting at
// start_addr. Each word goes out as a 7-byte packet through a byte-level UART
// transmitter: cmd, addr lo, addr hi, then data bytes LSB first.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   start                 one-cycle dump request (only honoured in IDLE)
//   sel_im                1 = instruction memory, 0 = data memory
//   start_addr            first packet/memory address
//   word_count            number of words to dump (0 = immediate done)
//   abort                 finish the byte in flight, then stop
//   mem_rd_en             one-cycle read strobe
//   mem_sel_im            memory select, held for the whole dump
//   mem_addr              read address, also the packet address field
//   mem_rdata             read data, valid one cycle after mem_rd_en
//   tx_data, trmt         byte and one-cycle strobe to the UART transmitter
//   tx_done               byte-complete pulse from the transmitter
//   busy                  dump in progress
//   done                  one-cycle completion/abort pulse
module uart_dump #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 16,
  parameter logic [7:0]  DM_CMD  = 8'h02,
  parameter logic [7:0]  IM_CMD  = 8'h04,
  parameter int          DM_STEP = 4,
  parameter int          IM_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_im,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic              mem_sel_im,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_WAIT_TX,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] IM_INC    = ADDR_W'(IM_STEP);
  localparam logic [ADDR_W-1:0] DM_INC    = ADDR_W'(DM_STEP);
  localparam logic [2:0]        LAST_BYTE = 3'd6;

  state_t            state;
  logic [DATA_W-1:0] data_q;     // word being serialised
  logic [ADDR_W-1:0] remaining;  // words left, including the current one
  logic [2:0]        byte_idx;   // packet byte currently on tx_data
  logic              abort_q;    // sticky abort request for this dump

  // Packet byte selector. The address bytes come from mem_addr, which stays
  // on the current word's address until NEXT advances it.
  function automatic logic [7:0] pkt_byte(
    input logic [2:0]        idx,
    input logic              im,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = im ? IM_CMD : DM_CMD;
      3'd1:    b = addr[7:0];
      3'd2:    b = addr[15:8];
      3'd3:    b = data[7:0];
      3'd4:    b = data[15:8];
      3'd5:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_rd_en  <= 1'b0;
      mem_sel_im <= 1'b0;
      mem_addr   <= '0;
      tx_data    <= 8'h00;
      trmt       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_q     <= '0;
      remaining  <= '0;
      byte_idx   <= '0;
      abort_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below.
      mem_rd_en <= 1'b0;
      trmt      <= 1'b0;
      done      <= 1'b0;
      abort_q   <= abort_q | abort;

      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              mem_sel_im <= sel_im;
              mem_addr   <= start_addr;
              remaining  <= word_count;
              busy       <= 1'b1;
              mem_rd_en  <= 1'b1;
              state      <= S_READ;
            end
          end
        end

        S_READ: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // Byte 0 is the tag, so the word being captured here is not needed
          // until byte 3.
          data_q   <= mem_rdata;
          byte_idx <= 3'd0;
          tx_data  <= pkt_byte(3'd0, mem_sel_im, mem_addr, mem_rdata);
          trmt     <= 1'b1;
          state    <= S_LOAD;
        end

        S_LOAD: begin
          // A tx_done coinciding with trmt belongs to no byte of ours and is
          // dropped simply by not looking at it here.
          state <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (tx_done) begin
            if (abort_q || abort) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= pkt_byte(byte_idx + 3'd1, mem_sel_im, mem_addr, data_q);
              trmt     <= 1'b1;
              state    <= S_LOAD;
            end else begin
              state <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          remaining <= remaining - 1'b1;
          mem_addr  <= mem_addr + (mem_sel_im ? IM_INC : DM_INC);
          // An abort seen between packets stops before the next read.
          if (remaining == 1 || abort_q || abort) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            mem_rd_en <= 1'b1;
            state     <= S_READ;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
